gtxe2_chnl_rx_dataiface: RTL and testbench

//  RX-side counterpart of the TX data interface: packs narrow internal words
//  (internal_data_width + K flags) arriving at usrclk into wide interface words
//  (interface_data_width + K flags). Single-clock gearbox on usrclk: no FIFO,
//  no clock crossing. Sits between the RX 8b/10b decoder / comma aligner and the

---
 rtl/gtxe2_chnl_rx_dataiface.sv | 121 ++++++++++++
 tb/tb_gtxe2_chnl_rx_dataiface.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gtxe2_chnl_rx_dataiface.sv
// gtxe2_chnl_rx_dataiface
// RX data-width gearbox. It packs narrow decoded words (data + K flags) into
// wide fabric words on a single clock (usrclk). Lane 0 holds the first accepted
// word. The module emits one outvalid strobe per assembled wide word.
// Optional feature macro: GTXE2_RX_DATAIFACE_REALIGN_EN. When it is defined,
// a comma that arrives mid-word drops the partial word and restarts assembly
// with the comma in lane 0.
module gtxe2_chnl_rx_dataiface #(
  parameter int internal_data_width  = 16,
  parameter int interface_data_width = 32,
  parameter int internal_isk_width   = 2,
  parameter int interface_isk_width  = 4
) (
  input  logic                            usrclk,
  input  logic                            reset,
  input  logic [internal_data_width-1:0]  indata,
  input  logic [internal_isk_width-1:0]   inisk,
  input  logic                            invalid,
  input  logic                            incomma,
  output logic [interface_data_width-1:0] outdata,
  output logic [interface_isk_width-1:0]  outisk,
  output logic                            outvalid,
  output logic                            realigned
);

  localparam int DIV   = interface_data_width / internal_data_width;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  // Reject width combinations the gearbox cannot pack evenly.
  generate
    if (!(DIV == 1 || DIV == 2 || DIV == 4) ||
        (interface_data_width != DIV * internal_data_width) ||
        (interface_isk_width != DIV * internal_isk_width)) begin : g_bad_params
      $fatal(1, "gtxe2_chnl_rx_dataiface: illegal width parameters");
    end
  endgenerate

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [interface_data_width-1:0] stage_data_q, stage_data_d;
  logic [interface_isk_width-1:0]  stage_isk_q, stage_isk_d;
  logic [interface_data_width-1:0] outdata_q, outdata_d;
  logic [interface_isk_width-1:0]  outisk_q, outisk_d;
  logic                            outvalid_q, outvalid_d;
  logic                            realigned_q, realigned_d;
  logic                            realign_hit;

`ifdef GTXE2_RX_DATAIFACE_REALIGN_EN
  // A comma that arrives mid-word means the earlier lanes were misaligned.
  assign realign_hit = invalid & incomma & (cnt_q != '0);
`else
  logic unused_incomma;
  assign unused_incomma = incomma;
  assign realign_hit    = 1'b0;
`endif

  // Next-state logic: stage lanes, complete the word on the last lane, handle realignment.
  always_comb begin
    cnt_d        = cnt_q;
    stage_data_d = stage_data_q;
    stage_isk_d  = stage_isk_q;
    outdata_d    = outdata_q;
    outisk_d     = outisk_q;
    outvalid_d   = 1'b0;
    realigned_d  = 1'b0;
    if (invalid) begin
      if (realign_hit) begin
        // Drop the partial word and restart it with the comma in lane 0.
        stage_data_d = '0;
        stage_isk_d  = '0;
        stage_data_d[internal_data_width-1:0] = indata;
        stage_isk_d[internal_isk_width-1:0]   = inisk;
        cnt_d        = CNT_W'(1);
        realigned_d  = 1'b1;
      end else if (cnt_q == LAST_CNT) begin
        // Build the whole output word from the staged lanes and the current word.
        outdata_d = stage_data_q;
        outisk_d  = stage_isk_q;
        outdata_d[interface_data_width-1 -: internal_data_width] = indata;
        outisk_d[interface_isk_width-1 -: internal_isk_width]    = inisk;
        outvalid_d = 1'b1;
        cnt_d      = '0;
      end else begin
        for (int i = 0; i < DIV - 1; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            stage_data_d[i*internal_data_width +: internal_data_width] = indata;
            stage_isk_d[i*internal_isk_width +: internal_isk_width]    = inisk;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers. Reset asserts asynchronously.
  always_ff @(posedge usrclk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      stage_data_q <= '0;
      stage_isk_q  <= '0;
      outdata_q    <= '0;
      outisk_q     <= '0;
      outvalid_q   <= 1'b0;
      realigned_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stage_data_q <= stage_data_d;
      stage_isk_q  <= stage_isk_d;
      outdata_q    <= outdata_d;
      outisk_q     <= outisk_d;
      outvalid_q   <= outvalid_d;
      realigned_q  <= realigned_d;
    end
  end

  assign outdata   = outdata_q;
  assign outisk    = outisk_q;
  assign outvalid  = outvalid_q;
  assign realigned = realigned_q;

endmodule

// File: tb/tb_gtxe2_chnl_rx_dataiface.sv
// Directed bench for gtxe2_chnl_rx_dataiface.
// It uses three instances: div=2 (32/16), div=4 (64/16) and div=1 (16/16).
// The comma tests follow GTXE2_RX_DATAIFACE_REALIGN_EN.
module tb_gtxe2_chnl_rx_dataiface;

  logic usrclk = 1'b0;
  logic reset  = 1'b1;
  always #5 usrclk = ~usrclk;

  int total = 0;
  int bad   = 0;

  // div = 2
  logic [15:0] a_indata = '0;
  logic [1:0]  a_inisk = '0;
  logic        a_invalid = 1'b0, a_incomma = 1'b0;
  logic [31:0] a_outdata;
  logic [3:0]  a_outisk;
  logic        a_outvalid, a_realigned;

  // div = 4
  logic [15:0] b_indata = '0;
  logic [1:0]  b_inisk = '0;
  logic        b_invalid = 1'b0, b_incomma = 1'b0;
  logic [63:0] b_outdata;
  logic [7:0]  b_outisk;
  logic        b_outvalid, b_realigned;

  // div = 1
  logic [15:0] c_indata = '0;
  logic [1:0]  c_inisk = '0;
  logic        c_invalid = 1'b0, c_incomma = 1'b0;
  logic [15:0] c_outdata;
  logic [1:0]  c_outisk;
  logic        c_outvalid, c_realigned;

  gtxe2_chnl_rx_dataiface #(
    .internal_data_width(16), .interface_data_width(32),
    .internal_isk_width(2),   .interface_isk_width(4)
  ) dut (
    .usrclk(usrclk), .reset(reset), .indata(a_indata), .inisk(a_inisk),
    .invalid(a_invalid), .incomma(a_incomma), .outdata(a_outdata),
    .outisk(a_outisk), .outvalid(a_outvalid), .realigned(a_realigned)
  );

  gtxe2_chnl_rx_dataiface #(
    .internal_data_width(16), .interface_data_width(64),
    .internal_isk_width(2),   .interface_isk_width(8)
  ) dut4 (
    .usrclk(usrclk), .reset(reset), .indata(b_indata), .inisk(b_inisk),
    .invalid(b_invalid), .incomma(b_incomma), .outdata(b_outdata),
    .outisk(b_outisk), .outvalid(b_outvalid), .realigned(b_realigned)
  );

  gtxe2_chnl_rx_dataiface #(
    .internal_data_width(16), .interface_data_width(16),
    .internal_isk_width(2),   .interface_isk_width(2)
  ) dut1 (
    .usrclk(usrclk), .reset(reset), .indata(c_indata), .inisk(c_inisk),
    .invalid(c_invalid), .incomma(c_incomma), .outdata(c_outdata),
    .outisk(c_outisk), .outvalid(c_outvalid), .realigned(c_realigned)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each step drives one word and then samples 1 time unit after the clock edge.
  task automatic step_a(input logic [15:0] d, input logic [1:0] k, input logic v, input logic c);
    a_indata = d; a_inisk = k; a_invalid = v; a_incomma = c;
    @(posedge usrclk); #1;
    $display("A in=%h isk=%b v=%b comma=%b -> out=%h isk=%b ov=%b rl=%b",
             d, k, v, c, a_outdata, a_outisk, a_outvalid, a_realigned);
  endtask

  task automatic step_b(input logic [15:0] d, input logic [1:0] k, input logic v);
    b_indata = d; b_inisk = k; b_invalid = v;
    @(posedge usrclk); #1;
    $display("B in=%h isk=%b v=%b -> out=%h isk=%b ov=%b", d, k, v, b_outdata, b_outisk, b_outvalid);
  endtask

  task automatic step_c(input logic [15:0] d, input logic [1:0] k, input logic v);
    c_indata = d; c_inisk = k; c_invalid = v;
    @(posedge usrclk); #1;
    $display("C in=%h isk=%b v=%b -> out=%h isk=%b ov=%b", d, k, v, c_outdata, c_outisk, c_outvalid);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge usrclk);
    #1;
    chk("rst_outdata",   a_outdata, 64'h0);
    chk("rst_outisk",    a_outisk, 64'h0);
    chk("rst_outvalid",  a_outvalid, 64'h0);
    chk("rst_realigned", a_realigned, 64'h0);
    chk("rst_b_outdata", b_outdata, 64'h0);
    @(negedge usrclk); reset = 1'b0;
    @(posedge usrclk); #1;

    // 1: two-word assembly and the isk order
    step_a(16'h1111, 2'b01, 1'b1, 1'b0);
    chk("t1_no_early_valid", a_outvalid, 64'h0);
    step_a(16'h2222, 2'b00, 1'b1, 1'b0);
    chk("t1_outvalid", a_outvalid, 64'h1);
    chk("t1_outdata",  a_outdata, 64'h22221111);
    chk("t1_outisk",   a_outisk, 64'h1);
    step_a(16'h0000, 2'b00, 1'b0, 1'b0);
    chk("t1_strobe_one_cycle", a_outvalid, 64'h0);
    chk("t1_hold",             a_outdata, 64'h22221111);

    // 2: gaps between words
    step_a(16'hAAAA, 2'b10, 1'b1, 1'b0);
    chk("t2_first", a_outvalid, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step_a(16'hFFFF, 2'b11, 1'b0, 1'b0);
      chk("t2_gap_novalid", a_outvalid, 64'h0);
    end
    step_a(16'hBBBB, 2'b11, 1'b1, 1'b0);
    chk("t2_outvalid", a_outvalid, 64'h1);
    chk("t2_outdata",  a_outdata, 64'hBBBBAAAA);
    chk("t2_outisk",   a_outisk, 64'hE);

    // 3: div=4 ordering
    step_b(16'h1100, 2'b01, 1'b1);
    chk("t3_w0_novalid", b_outvalid, 64'h0);
    step_b(16'h3322, 2'b00, 1'b1);
    chk("t3_w1_novalid", b_outvalid, 64'h0);
    step_b(16'h5544, 2'b10, 1'b1);
    chk("t3_w2_novalid", b_outvalid, 64'h0);
    step_b(16'h7766, 2'b11, 1'b1);
    chk("t3_outvalid", b_outvalid, 64'h1);
    chk("t3_outdata",  b_outdata, 64'h7766554433221100);
    chk("t3_outisk",   b_outisk, 64'hE1);
    step_b(16'h0000, 2'b00, 1'b0);
    chk("t3_strobe_one_cycle", b_outvalid, 64'h0);

    // div=1 passthrough
    step_c(16'hCAFE, 2'b10, 1'b1);
    chk("d1_outvalid", c_outvalid, 64'h1);
    chk("d1_outdata",  c_outdata, 64'hCAFE);
    chk("d1_outisk",   c_outisk, 64'h2);
    step_c(16'h0000, 2'b00, 1'b0);
    chk("d1_idle", c_outvalid, 64'h0);

    // 4: reset in the middle of a word
    step_a(16'h1111, 2'b01, 1'b1, 1'b0);
    a_invalid = 1'b0;
    reset = 1'b1;
    #2;
    chk("t4_async_outdata", a_outdata, 64'h0);
    chk("t4_async_outisk",  a_outisk, 64'h0);
    chk("t4_async_b_data",  b_outdata, 64'h0);
    @(negedge usrclk); reset = 1'b0;
    step_a(16'h3333, 2'b00, 1'b1, 1'b0);
    chk("t4_no_stale_valid", a_outvalid, 64'h0);
    step_a(16'h4444, 2'b00, 1'b1, 1'b0);
    chk("t4_outvalid", a_outvalid, 64'h1);
    chk("t4_outdata",  a_outdata, 64'h44443333);

    // 5/6: comma in the middle of a word
    step_a(16'h5555, 2'b00, 1'b1, 1'b0);
    step_a(16'hBC50, 2'b01, 1'b1, 1'b1);
`ifdef GTXE2_RX_DATAIFACE_REALIGN_EN
    chk("t5_realigned", a_realigned, 64'h1);
    chk("t5_no_valid",  a_outvalid, 64'h0);
    step_a(16'h6666, 2'b00, 1'b1, 1'b0);
    chk("t5_realign_one_cycle", a_realigned, 64'h0);
    chk("t5_outvalid", a_outvalid, 64'h1);
    chk("t5_outdata",  a_outdata, 64'h6666BC50);
    chk("t5_outisk",   a_outisk, 64'h1);
`else
    chk("t6_outvalid",  a_outvalid, 64'h1);
    chk("t6_outdata",   a_outdata, 64'hBC505555);
    chk("t6_outisk",    a_outisk, 64'h4);
    chk("t6_realigned", a_realigned, 64'h0);
    step_a(16'h6666, 2'b00, 1'b1, 1'b0);
    chk("t6_staged_novalid", a_outvalid, 64'h0);
    chk("t6_realigned_low",  a_realigned, 64'h0);
    // Complete the pending word so that the counter returns to 0.
    step_a(16'h6767, 2'b00, 1'b1, 1'b0);
    chk("t6_tail_data", a_outdata, 64'h67676666);
`endif

    // A comma at count 0 is normal operation in both builds.
    step_a(16'hBC50, 2'b01, 1'b1, 1'b1);
    chk("c0_no_realign", a_realigned, 64'h0);
    chk("c0_no_valid",   a_outvalid, 64'h0);
    step_a(16'h7777, 2'b00, 1'b1, 1'b0);
    chk("c0_outvalid", a_outvalid, 64'h1);
    chk("c0_outdata",  a_outdata, 64'h7777BC50);
    step_a(16'h0000, 2'b00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
